// File: rtl/inst_seq_pkg.sv
// Shared definitions for the instruction sequencer: FSM states, instruction-word
// field positions and the idle instruction word.
package inst_seq_pkg;

  localparam int INST_W = 51;
  localparam int ADDR_W = 11;

  localparam int BIT_LOAD     = 0;
  localparam int BIT_EXECUTE  = 1;
  localparam int BIT_L0_WR    = 2;
  localparam int BIT_L0_RD    = 3;
  localparam int BIT_IFIFO_RD = 4;
  localparam int BIT_IFIFO_WR = 5;
  localparam int BIT_OFIFO_RD = 6;
  localparam int BIT_A_XMEM   = 7;
  localparam int BIT_WEN_XMEM = 18;
  localparam int BIT_CEN_XMEM = 19;
  localparam int BIT_A_PMEM   = 20;
  localparam int BIT_WEN_PMEM = 31;
  localparam int BIT_CEN_PMEM = 32;
  localparam int BIT_ACC      = 33;
  localparam int BIT_SFP_CLR  = 34;

  // Both memories deselected and read-enabled, every control strobe low.
  localparam logic [INST_W-1:0] IDLE_WORD =
    (INST_W'(1) << BIT_CEN_PMEM) | (INST_W'(1) << BIT_WEN_PMEM) |
    (INST_W'(1) << BIT_CEN_XMEM) | (INST_W'(1) << BIT_WEN_XMEM);

  typedef enum logic [3:0] {
    S_IDLE,
    S_WL0,
    S_LOAD,
    S_GAP,
    S_AL0,
    S_EXEC,
    S_FLUSH,
    S_DRAIN,
    S_ACC_CLR,
    S_ACC_RD,
    S_ACC_OUT
  } state_t;

  function automatic logic [INST_W-1:0] put_addr(input logic [INST_W-1:0] w,
                                                 input int lsb,
                                                 input logic [ADDR_W-1:0] a);
    logic [INST_W-1:0] r;
    r = w;
    r[lsb +: ADDR_W] = a;
    return r;
  endfunction

endpackage

// File: rtl/acc_addr_gen.sv
// Combinational pmem address of the psum that kernel offset j contributes to
// output pixel onij during the accumulation pass.
module acc_addr_gen
  import inst_seq_pkg::*;
#(
  parameter int LEN_NIJ = 36,
  parameter int IN_W    = 6,
  parameter int K       = 3,
  parameter int O_W     = 4
) (
  input  logic [3:0]        j,
  input  logic [3:0]        onij,
  output logic [ADDR_W-1:0] addr
);

  logic [3:0] orow, ocol, krow, kcol;

  always_comb begin
    orow = onij / 4'(O_W);
    ocol = onij % 4'(O_W);
    krow = j / 4'(K);
    kcol = j % 4'(K);
    addr = ADDR_W'(j) * ADDR_W'(LEN_NIJ)
         + (ADDR_W'(orow) + ADDR_W'(krow)) * ADDR_W'(IN_W)
         + ADDR_W'(ocol) + ADDR_W'(kcol);
  end

endmodule

// File: rtl/inst_sequencer.sv
// Drives the core instruction bus through the full kij loop and, when
// INST_SEQ_ACC_EN is defined, the per-output accumulation pass.
module inst_sequencer
  import inst_seq_pkg::*;
#(
  parameter int COL     = 8,
  parameter int ROW     = 8,
  parameter int LEN_NIJ = 36,
  parameter int IN_W    = 6,
  parameter int K       = 3,
  parameter int O_W     = 4,
  parameter int GAP_CYC = 10,
  parameter logic [ADDR_W-1:0] W_BASE = 11'h400
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              ofifo_valid,
  output logic [INST_W-1:0] inst,
  output logic              busy,
  output logic              done,
  output logic [3:0]        kij,
  output logic              onij_valid,
  output logic [3:0]        onij
);

  localparam int LEN_KIJ = K * K;

  localparam logic [7:0] COL_N      = 8'(COL);
  localparam logic [7:0] LOAD_LAST  = 8'(COL - 1);
  localparam logic [7:0] GAP_LAST   = 8'(GAP_CYC - 1);
  localparam logic [7:0] NIJ_N      = 8'(LEN_NIJ);
  localparam logic [7:0] NIJ_LAST   = 8'(LEN_NIJ - 1);
  localparam logic [7:0] FLUSH_LAST = 8'(ROW + COL - 1);
  localparam logic [3:0] KIJ_LAST   = 4'(LEN_KIJ - 1);
  localparam logic [ADDR_W-1:0] COL_A = ADDR_W'(COL);
  localparam logic [ADDR_W-1:0] NIJ_A = ADDR_W'(LEN_NIJ);

`ifdef INST_SEQ_ACC_EN
  localparam logic [7:0] KIJ_N      = 8'(LEN_KIJ);
  localparam logic [3:0] ONIJ_LAST  = 4'(O_W * O_W - 1);
`endif

  state_t            state, state_next;
  logic [7:0]        step, step_next;
  logic [3:0]        kij_cnt, kij_next;
  logic              run_end;
  logic              done_d1;
  logic [INST_W-1:0] word;

`ifdef INST_SEQ_ACC_EN
  logic [3:0]        onij_cnt, onij_next;
  logic              ov_c;
  logic [ADDR_W-1:0] acc_addr;

  acc_addr_gen #(
    .LEN_NIJ (LEN_NIJ),
    .IN_W    (IN_W),
    .K       (K),
    .O_W     (O_W)
  ) u_acc_addr (
    .j    (step[3:0]),
    .onij (onij_cnt),
    .addr (acc_addr)
  );
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      step    <= '0;
      kij_cnt <= '0;
`ifdef INST_SEQ_ACC_EN
      onij_cnt <= '0;
`endif
    end else begin
      state   <= state_next;
      step    <= step_next;
      kij_cnt <= kij_next;
`ifdef INST_SEQ_ACC_EN
      onij_cnt <= onij_next;
`endif
    end
  end

  // step counts cycles within a phase; in DRAIN it counts completed writes.
  always_comb begin
    state_next = state;
    step_next  = step;
    kij_next   = kij_cnt;
    run_end    = 1'b0;
`ifdef INST_SEQ_ACC_EN
    onij_next  = onij_cnt;
`endif
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_WL0;
          step_next  = '0;
          kij_next   = '0;
`ifdef INST_SEQ_ACC_EN
          onij_next  = '0;
`endif
        end
      end
      S_WL0: begin
        if (step == COL_N) begin
          state_next = S_LOAD;
          step_next  = '0;
        end else step_next = step + 8'd1;
      end
      S_LOAD: begin
        if (step == LOAD_LAST) begin
          state_next = S_GAP;
          step_next  = '0;
        end else step_next = step + 8'd1;
      end
      S_GAP: begin
        if (step == GAP_LAST) begin
          state_next = S_AL0;
          step_next  = '0;
        end else step_next = step + 8'd1;
      end
      S_AL0: begin
        if (step == NIJ_N) begin
          state_next = S_EXEC;
          step_next  = '0;
        end else step_next = step + 8'd1;
      end
      S_EXEC: begin
        if (step == NIJ_LAST) begin
          state_next = S_FLUSH;
          step_next  = '0;
        end else step_next = step + 8'd1;
      end
      S_FLUSH: begin
        if (step == FLUSH_LAST) begin
          state_next = S_DRAIN;
          step_next  = '0;
        end else step_next = step + 8'd1;
      end
      S_DRAIN: begin
        if (ofifo_valid) begin
          if (step == NIJ_LAST) begin
            step_next = '0;
            if (kij_cnt == KIJ_LAST) begin
              kij_next = '0;
`ifdef INST_SEQ_ACC_EN
              state_next = S_ACC_CLR;
`else
              state_next = S_IDLE;
              run_end    = 1'b1;
`endif
            end else begin
              kij_next   = kij_cnt + 4'd1;
              state_next = S_WL0;
            end
          end else step_next = step + 8'd1;
        end
      end
`ifdef INST_SEQ_ACC_EN
      S_ACC_CLR: begin
        state_next = S_ACC_RD;
        step_next  = '0;
      end
      S_ACC_RD: begin
        if (step == KIJ_N) begin
          state_next = S_ACC_OUT;
          step_next  = '0;
        end else step_next = step + 8'd1;
      end
      S_ACC_OUT: begin
        if (onij_cnt == ONIJ_LAST) begin
          state_next = S_IDLE;
          onij_next  = '0;
          run_end    = 1'b1;
        end else begin
          state_next = S_ACC_CLR;
          onij_next  = onij_cnt + 4'd1;
        end
      end
`endif
      default: state_next = S_IDLE;
    endcase
  end

  // Instruction word for the current phase cycle; registered one cycle later.
  always_comb begin
    word = IDLE_WORD;
    word[BIT_IFIFO_WR] = 1'b0;
    word[BIT_IFIFO_RD] = 1'b0;
`ifdef INST_SEQ_ACC_EN
    ov_c = 1'b0;
`endif
    unique case (state)
      S_WL0: begin
        if (step < COL_N) begin
          word[BIT_CEN_XMEM] = 1'b0;
          word = put_addr(word, BIT_A_XMEM,
                          W_BASE + ADDR_W'(kij_cnt) * COL_A + ADDR_W'(step));
        end
        if (step != 8'd0) word[BIT_L0_WR] = 1'b1;
      end
      S_LOAD: begin
        word[BIT_L0_RD] = 1'b1;
        word[BIT_LOAD]  = 1'b1;
      end
      S_AL0: begin
        if (step < NIJ_N) begin
          word[BIT_CEN_XMEM] = 1'b0;
          word = put_addr(word, BIT_A_XMEM, ADDR_W'(step));
        end
        if (step != 8'd0) word[BIT_L0_WR] = 1'b1;
      end
      S_EXEC: begin
        word[BIT_EXECUTE] = 1'b1;
        word[BIT_L0_RD]   = 1'b1;
      end
      S_DRAIN: begin
        if (ofifo_valid) begin
          word[BIT_OFIFO_RD] = 1'b1;
          word[BIT_CEN_PMEM] = 1'b0;
          word[BIT_WEN_PMEM] = 1'b0;
          word = put_addr(word, BIT_A_PMEM,
                          ADDR_W'(kij_cnt) * NIJ_A + ADDR_W'(step));
        end
      end
`ifdef INST_SEQ_ACC_EN
      S_ACC_CLR: word[BIT_SFP_CLR] = 1'b1;
      S_ACC_RD: begin
        if (step < KIJ_N) begin
          word[BIT_CEN_PMEM] = 1'b0;
          word = put_addr(word, BIT_A_PMEM, acc_addr);
        end
        if (step != 8'd0) word[BIT_ACC] = 1'b1;
      end
      S_ACC_OUT: ov_c = 1'b1;
`endif
      default: ;
    endcase
  end

  // done trails the final word by one cycle; busy is held through it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inst    <= IDLE_WORD;
      busy    <= 1'b0;
      done    <= 1'b0;
      done_d1 <= 1'b0;
      kij     <= '0;
    end else begin
      inst    <= word;
      busy    <= (state != S_IDLE) || done_d1;
      done_d1 <= run_end;
      done    <= done_d1;
      kij     <= kij_cnt;
    end
  end

`ifdef INST_SEQ_ACC_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      onij_valid <= 1'b0;
      onij       <= '0;
    end else begin
      onij_valid <= ov_c;
      onij       <= onij_cnt;
    end
  end
`else
  assign onij_valid = 1'b0;
  assign onij       = '0;
`endif

endmodule
